// File: rtl/usrt_pkg.sv
// Shared USRT types and constants, used by the TX shifter and the parity/framing stage.
package usrt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } usrt_state_e;

  localparam int unsigned USRT_FRAME_W   = 11;
  localparam logic        USRT_LINE_IDLE = 1'b1;

endpackage

// File: rtl/usrt_baud_gen.sv
// Bit-period divider for the USRT TX path: produces the bit boundary tick and serial clock level.
// USRT_TX_SCLK_GATE_EN: sclk toggles only while gate is set and the divider idles at 0 when not running.
module usrt_baud_gen
  import usrt_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  input  logic gate,
  output logic bit_tick,
  output logic sclk_lvl
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             sclk_q;
  logic             sclk_d;

  // Next divider count and the sclk level it implies; sclk is low for the first half of each bit
  always_comb begin
    div_d  = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
    sclk_d = USRT_LINE_IDLE;
`ifdef USRT_TX_SCLK_GATE_EN
    if (restart || !run) div_d = '0;
    sclk_d = gate ? (div_d >= DIV_HALF) : USRT_LINE_IDLE;
`else
    if (restart) div_d = '0;
    sclk_d = (div_d >= DIV_HALF);
`endif
  end

`ifndef USRT_TX_SCLK_GATE_EN
  logic unused_gate_ctrl;
  assign unused_gate_ctrl = run ^ gate;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      sclk_q <= USRT_LINE_IDLE;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign bit_tick = (div_q == DIV_MAX);
  assign sclk_lvl = sclk_q;

endmodule

// File: rtl/usrt_tx_shifter.sv
// USRT TX serialiser: accepts an assembled frame and shifts it out LSB first with a bit clock.
// USRT_TX_SCLK_GATE_EN selects a gated (SHIFT-only) serial clock; default is free-running.
module usrt_tx_shifter
  import usrt_pkg::*;
#(
  parameter int unsigned FRAME_W  = USRT_FRAME_W,
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic               i_Pclk,
  input  logic               i_Reset,
  input  logic [FRAME_W-1:0] i_Frame,
  input  logic               i_Valid,
  output logic               o_Ready,
  output logic               o_Tx,
  output logic               o_Sclk,
  output logic               o_Busy,
  output logic               o_Done
);

  localparam int unsigned BIT_W = $clog2(FRAME_W + 1);
  localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = (GAP_BITS > 0) ? GAP_W'(GAP_BITS - 1) : '0;

  usrt_state_e        state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               accept;
  logic               bit_tick;
  logic               sclk_lvl;
  logic               tx_q, ready_q, busy_q, done_q;

  usrt_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk      (i_Pclk),
    .rst      (i_Reset),
    .restart  (accept),
    .run      ((state_d == SHIFT) || (state_d == GAP)),
    .gate     (state_d == SHIFT),
    .bit_tick (bit_tick),
    .sclk_lvl (sclk_lvl)
  );

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state plus datapath updates; the shift register refills with idle level as it drains
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
          sr_d    = i_Frame;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          sr_d  = {USRT_LINE_IDLE, sr_q[FRAME_W-1:1]};
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) begin
            gap_d   = '0;
            state_d = (GAP_BITS > 0) ? GAP : DONE;
          end
        end
      end
      GAP: begin
        if (bit_tick) begin
          if (gap_q == LAST_GAP) state_d = DONE;
          else                   gap_d   = gap_q + GAP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered line/status outputs, all derived from the upcoming state
  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      sr_q    <= '1;
      bit_q   <= '0;
      gap_q   <= '0;
      tx_q    <= USRT_LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_q    <= (state_d == SHIFT) ? sr_d[0] : USRT_LINE_IDLE;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign o_Tx    = tx_q;
  assign o_Sclk  = sclk_lvl;
  assign o_Ready = ready_q;
  assign o_Busy  = busy_q;
  assign o_Done  = done_q;

endmodule

// File: tb/tb_usrt_tx_shifter.sv
// Randomised self-checking bench for usrt_tx_shifter against a cycle-timeline reference model.
module tb_usrt_tx_shifter;

  localparam int W = 11;
`ifdef USRT_TX_SCLK_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [W-1:0] frame0 = '0, frame1 = '0;
  logic         valid0 = 1'b0, valid1 = 1'b0;
  logic         ready0, tx0, sclk0, busy0, done0;
  logic         ready1, tx1, sclk1, busy1, done1;

  usrt_tx_shifter #(.FRAME_W(W), .CLK_DIV(4), .GAP_BITS(1)) u0 (
    .i_Pclk(clk), .i_Reset(rst), .i_Frame(frame0), .i_Valid(valid0),
    .o_Ready(ready0), .o_Tx(tx0), .o_Sclk(sclk0), .o_Busy(busy0), .o_Done(done0)
  );

  usrt_tx_shifter #(.FRAME_W(W), .CLK_DIV(2), .GAP_BITS(0)) u1 (
    .i_Pclk(clk), .i_Reset(rst), .i_Frame(frame1), .i_Valid(valid1),
    .o_Ready(ready1), .o_Tx(tx1), .o_Sclk(sclk1), .o_Busy(busy1), .o_Done(done1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] fq[4];
  int           acc_t[4];
  int           nacc;
  logic         tr_tx[256], tr_sclk[256], tr_busy[256], tr_done[256], tr_ready[256];
  logic [255:0] ex_tx, ex_sclk, ex_busy, ex_done, ex_ready;
  logic [255:0] ac_tx, ac_sclk, ac_busy, ac_done, ac_ready;

  task automatic drive(input int sel, input logic v, input logic [W-1:0] f);
    if (sel == 0) begin valid0 = v; frame0 = f; end
    else          begin valid1 = v; frame1 = f; end
  endtask

  // Upstream model: presents fq[0..n-1] in order, holding valid until each is taken; records a trace
  task automatic run_stream(input int sel, input int n, input int ncyc, input bit noise);
    int   k = 0;
    logic v;
    logic rdy;
    nacc = 0;
    acc_t[0] = 0;
    @(negedge clk);
    v = 1'b1;
    drive(sel, v, fq[0]);
    for (int t = 0; t < ncyc; t++) begin
      rdy         = (sel == 0) ? ready0 : ready1;
      tr_tx[t]    = (sel == 0) ? tx0    : tx1;
      tr_sclk[t]  = (sel == 0) ? sclk0  : sclk1;
      tr_busy[t]  = (sel == 0) ? busy0  : busy1;
      tr_done[t]  = (sel == 0) ? done0  : done1;
      tr_ready[t] = rdy;
      if (k < n && v && rdy) begin
        acc_t[k] = t;
        k++;
      end
      @(negedge clk);
      if (k < n)                              v = 1'b1;
      else if (noise && (t - acc_t[0]) < 46)  v = 1'($urandom % 2);
      else                                    v = 1'b0;
      drive(sel, v, (k < n) ? fq[k] : W'($urandom));
    end
    nacc = k;
  endtask

  // Reference timeline: frame k accepted at k*(frame time + 1); bits last div clks each, LSB first
  task automatic build_vectors(input int div, input int gap, input int n, input int ncyc);
    int flen;
    int c;
    int last_c;
    flen = 1 + (W + gap) * div;
    {ex_tx, ex_sclk, ex_busy, ex_done, ex_ready} = '0;
    {ac_tx, ac_sclk, ac_busy, ac_done, ac_ready} = '0;
    for (int i = 0; i < ncyc; i++) begin
      ex_tx[i] = 1'b1;
      last_c   = 0;
      for (int k = 0; k < n; k++) begin
        c = i - k * (flen + 1);
        if (c >= 1 && c <= W * div) ex_tx[i] = fq[k][(c - 1) / div];
        if (c >= 1 && c <= flen)    ex_busy[i] = 1'b1;
        if (c == flen)              ex_done[i] = 1'b1;
        if (c >= 1)                 last_c = c;
      end
      ex_ready[i] = ~ex_busy[i];
      ac_tx[i]    = tr_tx[i];
      ac_busy[i]  = tr_busy[i];
      ac_done[i]  = tr_done[i];
      ac_ready[i] = tr_ready[i];
      if (GATED) begin
        ex_sclk[i] = (last_c >= 1 && last_c <= W * div) ? (((last_c - 1) % div) >= div / 2) : 1'b1;
        ac_sclk[i] = tr_sclk[i];
      end else if (last_c >= 1) begin
        ex_sclk[i] = (((last_c - 1) % div) >= div / 2);
        ac_sclk[i] = tr_sclk[i];
      end
    end
  endtask

  task automatic test_reset();
    logic [19:0] a_tx, a_rdy, a_busy, a_done, a_sclk;
    rst = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a_tx[i] = tx0; a_rdy[i] = ready0; a_busy[i] = busy0; a_done[i] = done0; a_sclk[i] = sclk0;
    end
    n_tests++; if (a_tx !== 20'hFFFFF)   begin n_fail++; $display("FAIL reset_tx got=%h exp=fffff", a_tx); end
    n_tests++; if (a_rdy !== 20'hFFFFF)  begin n_fail++; $display("FAIL reset_ready got=%h exp=fffff", a_rdy); end
    n_tests++; if (a_busy !== 20'h00000) begin n_fail++; $display("FAIL reset_busy got=%h exp=00000", a_busy); end
    n_tests++; if (a_done !== 20'h00000) begin n_fail++; $display("FAIL reset_done got=%h exp=00000", a_done); end
    if (GATED) begin
      n_tests++; if (a_sclk !== 20'hFFFFF) begin n_fail++; $display("FAIL reset_sclk got=%h exp=fffff", a_sclk); end
    end
  endtask

  task automatic test_send();
    logic [W-1:0] rx;
    int           nrise;
    for (int f = 0; f < 4; f++) begin
      fq[0] = (f == 0) ? 11'b110_0000_0010 : W'($urandom);
      run_stream(0, 1, 52, 1'b0);
      build_vectors(4, 1, 1, 52);
      rx = '1;
      nrise = 0;
      for (int i = 1; i <= W * 4; i++) begin
        if (tr_sclk[i - 1] === 1'b0 && tr_sclk[i] === 1'b1) begin
          if (nrise < W) rx[nrise] = tr_tx[i];
          nrise++;
        end
      end
      n_tests++; if (nacc !== 1 || acc_t[0] !== 0) begin n_fail++; $display("FAIL send%0d_accept got n=%0d t=%0d exp n=1 t=0", f, nacc, acc_t[0]); end
      n_tests++; if (ac_tx !== ex_tx)     begin n_fail++; $display("FAIL send%0d_tx got=%h exp=%h", f, ac_tx, ex_tx); end
      n_tests++; if (ac_sclk !== ex_sclk) begin n_fail++; $display("FAIL send%0d_sclk got=%h exp=%h", f, ac_sclk, ex_sclk); end
      n_tests++; if (ac_done !== ex_done) begin n_fail++; $display("FAIL send%0d_done got=%h exp=%h", f, ac_done, ex_done); end
      n_tests++; if (ac_busy !== ex_busy || ac_ready !== ex_ready) begin n_fail++; $display("FAIL send%0d_busy_ready got=%h/%h exp=%h/%h", f, ac_busy, ac_ready, ex_busy, ex_ready); end
      n_tests++; if (rx !== fq[0] || nrise !== W) begin n_fail++; $display("FAIL send%0d_sclk_sample got=%h (%0d rises) exp=%h (%0d rises)", f, rx, nrise, fq[0], W); end
    end
  endtask

  task automatic test_back_to_back();
    fq[0] = W'($urandom);
    fq[1] = W'($urandom);
    run_stream(0, 2, 105, 1'b0);
    build_vectors(4, 1, 2, 105);
    n_tests++; if (nacc !== 2 || (acc_t[1] - acc_t[0]) !== 50) begin n_fail++; $display("FAIL b2b_spacing got n=%0d d=%0d exp n=2 d=50", nacc, acc_t[1] - acc_t[0]); end
    n_tests++; if (ac_tx !== ex_tx)     begin n_fail++; $display("FAIL b2b_tx got=%h exp=%h", ac_tx, ex_tx); end
    n_tests++; if (ac_done !== ex_done) begin n_fail++; $display("FAIL b2b_done got=%h exp=%h", ac_done, ex_done); end
    n_tests++; if (ac_sclk !== ex_sclk) begin n_fail++; $display("FAIL b2b_sclk got=%h exp=%h", ac_sclk, ex_sclk); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] f;
    f = 11'b110_0000_0010;
    @(negedge clk);
    drive(0, 1'b1, f);
    @(negedge clk);
    drive(0, 1'b0, W'($urandom));
    repeat (21) @(negedge clk);
    n_tests++; if (tx0 !== f[5]) begin n_fail++; $display("FAIL midrst_bit5 got=%b exp=%b", tx0, f[5]); end
    rst = 1'b1;
    #1;
    n_tests++; if ({tx0, busy0, ready0, done0, sclk0} !== 5'b10101) begin n_fail++; $display("FAIL midrst_outputs got=%b exp=10101", {tx0, busy0, ready0, done0, sclk0}); end
    @(negedge clk);
    rst = 1'b0;
    fq[0] = 11'b111_1111_1110;
    run_stream(0, 1, 52, 1'b0);
    build_vectors(4, 1, 1, 52);
    n_tests++; if (ac_tx !== ex_tx || ac_busy !== ex_busy) begin n_fail++; $display("FAIL midrst_resend got=%h/%h exp=%h/%h", ac_tx, ac_busy, ex_tx, ex_busy); end
  endtask

  task automatic test_gap0();
    for (int k = 0; k < 3; k++) fq[k] = W'($urandom);
    run_stream(1, 3, 76, 1'b0);
    build_vectors(2, 0, 3, 76);
    n_tests++; if (nacc !== 3 || (acc_t[1] - acc_t[0]) !== 24 || (acc_t[2] - acc_t[1]) !== 24) begin n_fail++; $display("FAIL gap0_spacing got n=%0d d=%0d,%0d exp n=3 d=24,24", nacc, acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]); end
    n_tests++; if (ac_tx !== ex_tx)     begin n_fail++; $display("FAIL gap0_tx got=%h exp=%h", ac_tx, ex_tx); end
    n_tests++; if (ac_done !== ex_done) begin n_fail++; $display("FAIL gap0_done got=%h exp=%h", ac_done, ex_done); end
    n_tests++; if (ac_sclk !== ex_sclk) begin n_fail++; $display("FAIL gap0_sclk got=%h exp=%h", ac_sclk, ex_sclk); end
  endtask

  task automatic test_busy_noise();
    for (int r = 0; r < 2; r++) begin
      fq[0] = W'($urandom);
      run_stream(0, 1, 64, 1'b1);
      build_vectors(4, 1, 1, 64);
      n_tests++; if (ac_tx !== ex_tx)     begin n_fail++; $display("FAIL noise%0d_tx got=%h exp=%h", r, ac_tx, ex_tx); end
      n_tests++; if (ac_busy !== ex_busy) begin n_fail++; $display("FAIL noise%0d_busy got=%h exp=%h", r, ac_busy, ex_busy); end
      n_tests++; if (ac_done !== ex_done) begin n_fail++; $display("FAIL noise%0d_done got=%h exp=%h", r, ac_done, ex_done); end
    end
  endtask

  initial begin
    test_reset();
    test_send();
    test_back_to_back();
    test_reset_mid();
    test_gap0();
    test_busy_noise();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
